// File: rtl/dual_issue_regfile.sv
// Architectural register file for the dual-issue pipeline: r1..r31 plus HI/LO,
// four combinational read ports and two write-back ports with optional write-through.
module dual_issue_regfile #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        master_wb_reg_en,
    input  logic [4:0]  master_wb_addr,
    input  logic [31:0] master_wb_data,
    input  logic        slave_wb_reg_en,
    input  logic [4:0]  slave_wb_addr,
    input  logic [31:0] slave_wb_data,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic [31:0] hi_wdata,
    input  logic [31:0] lo_wdata,
    input  logic [4:0]  master_rs_addr,
    input  logic [4:0]  master_rt_addr,
    input  logic [4:0]  slave_rs_addr,
    input  logic [4:0]  slave_rt_addr,
    output logic [31:0] master_rs_data,
    output logic [31:0] master_rt_data,
    output logic [31:0] slave_rs_data,
    output logic [31:0] slave_rt_data,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    logic [31:0] regs [1:31];
    logic [31:0] hi;
    logic [31:0] lo;

    logic master_wr;
    logic slave_wr;

    assign master_wr = master_wb_reg_en && (master_wb_addr != 5'd0);
    assign slave_wr  = slave_wb_reg_en  && (slave_wb_addr  != 5'd0);

    // Slave write is issued last so it wins a same-address collision (younger instruction).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
            hi <= '0;
            lo <= '0;
        end else begin
            if (master_wr) begin
                regs[master_wb_addr] <= master_wb_data;
            end
            if (slave_wr) begin
                regs[slave_wb_addr] <= slave_wb_data;
            end
            if (hi_wen) begin
                hi <= hi_wdata;
            end
            if (lo_wen) begin
                lo <= lo_wdata;
            end
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (WB_BYPASS && rst_n && slave_wr && (slave_wb_addr == addr)) begin
            val = slave_wb_data;
        end else if (WB_BYPASS && rst_n && master_wr && (master_wb_addr == addr)) begin
            val = master_wb_data;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        master_rs_data = read_port(master_rs_addr);
        master_rt_data = read_port(master_rt_addr);
        slave_rs_data  = read_port(slave_rs_addr);
        slave_rt_data  = read_port(slave_rt_addr);
    end

    always_comb begin
        hi_rdata = (WB_BYPASS && rst_n && hi_wen) ? hi_wdata : hi;
        lo_rdata = (WB_BYPASS && rst_n && lo_wen) ? lo_wdata : lo;
    end

endmodule

// File: tb/tb_dual_issue_regfile.sv
// Table-driven bench for dual_issue_regfile: a bypassing and a non-bypassing
// instance share stimulus; each has its own hand-computed expectations.
module tb_dual_issue_regfile;

    logic        clk;
    logic        rst_n;
    logic        m_en, s_en, hi_wen, lo_wen;
    logic [4:0]  m_addr, s_addr;
    logic [31:0] m_data, s_data, hi_wd, lo_wd;
    logic [4:0]  ra [4];
    logic [31:0] ob [6];
    logic [31:0] on [6];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dual_issue_regfile #(.WB_BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .master_wb_reg_en(m_en), .master_wb_addr(m_addr), .master_wb_data(m_data),
        .slave_wb_reg_en(s_en), .slave_wb_addr(s_addr), .slave_wb_data(s_data),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wd), .lo_wdata(lo_wd),
        .master_rs_addr(ra[0]), .master_rt_addr(ra[1]),
        .slave_rs_addr(ra[2]), .slave_rt_addr(ra[3]),
        .master_rs_data(ob[0]), .master_rt_data(ob[1]),
        .slave_rs_data(ob[2]), .slave_rt_data(ob[3]),
        .hi_rdata(ob[4]), .lo_rdata(ob[5])
    );

    dual_issue_regfile #(.WB_BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n),
        .master_wb_reg_en(m_en), .master_wb_addr(m_addr), .master_wb_data(m_data),
        .slave_wb_reg_en(s_en), .slave_wb_addr(s_addr), .slave_wb_data(s_data),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .hi_wdata(hi_wd), .lo_wdata(lo_wd),
        .master_rs_addr(ra[0]), .master_rt_addr(ra[1]),
        .slave_rs_addr(ra[2]), .slave_rt_addr(ra[3]),
        .master_rs_data(on[0]), .master_rt_data(on[1]),
        .slave_rs_data(on[2]), .slave_rt_data(on[3]),
        .hi_rdata(on[4]), .lo_rdata(on[5])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        m_en;
        logic [4:0]  m_addr;
        logic [31:0] m_data;
        logic        s_en;
        logic [4:0]  s_addr;
        logic [31:0] s_data;
        logic        hi_wen;
        logic [31:0] hi_wd;
        logic        lo_wen;
        logic [31:0] lo_wd;
        logic [4:0]  ra [4];
        logic [31:0] eb [6];
        logic [31:0] en [6];
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(
        input logic r, input logic me, input logic [4:0] ma, input logic [31:0] md,
        input logic se, input logic [4:0] sa, input logic [31:0] sd,
        input logic hw, input logic [31:0] hd, input logic lw, input logic [31:0] ld,
        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
        input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
        input logic [31:0] b3, input logic [31:0] bh, input logic [31:0] bl,
        input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2,
        input logic [31:0] n3, input logic [31:0] nh, input logic [31:0] nl);
        vec_t v;
        v.rst_n = r; v.m_en = me; v.m_addr = ma; v.m_data = md;
        v.s_en = se; v.s_addr = sa; v.s_data = sd;
        v.hi_wen = hw; v.hi_wd = hd; v.lo_wen = lw; v.lo_wd = ld;
        v.ra[0] = a0; v.ra[1] = a1; v.ra[2] = a2; v.ra[3] = a3;
        v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2; v.eb[3] = b3; v.eb[4] = bh; v.eb[5] = bl;
        v.en[0] = n0; v.en[1] = n1; v.en[2] = n2; v.en[3] = n3; v.en[4] = nh; v.en[5] = nl;
        return v;
    endfunction

    string port_name [6] = '{"mrs", "mrt", "srs", "srt", "hi", "lo"};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_en = 1'b0; m_addr = '0; m_data = '0;
        s_en = 1'b0; s_addr = '0; s_data = '0;
        hi_wen = 1'b0; hi_wd = '0; lo_wen = 1'b0; lo_wd = '0;
        for (int k = 0; k < 4; k++) ra[k] = '0;
    endtask

    initial begin
        // {rst_n, m_en,m_addr,m_data, s_en,s_addr,s_data, hi_wen,hi_wd, lo_wen,lo_wd,
        //  4 read addrs, bypass expectations x6, no-bypass expectations x6}
        vecs.push_back(mk(1, 1,5,32'h1234_5678, 0,0,0, 0,0, 0,0, 5,5,5,5,
            32'h1234_5678,32'h1234_5678,32'h1234_5678,32'h1234_5678,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 5,5,5,5,
            32'h1234_5678,32'h1234_5678,32'h1234_5678,32'h1234_5678,0,0,
            32'h1234_5678,32'h1234_5678,32'h1234_5678,32'h1234_5678,0,0));
        vecs.push_back(mk(1, 1,9,32'hAAAA_AAAA, 1,9,32'h5555_5555, 0,0, 0,0, 9,9,5,0,
            32'h5555_5555,32'h5555_5555,32'h1234_5678,0,0,0, 0,0,32'h1234_5678,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 9,9,9,9,
            32'h5555_5555,32'h5555_5555,32'h5555_5555,32'h5555_5555,0,0,
            32'h5555_5555,32'h5555_5555,32'h5555_5555,32'h5555_5555,0,0));
        vecs.push_back(mk(1, 1,0,32'hFFFF_FFFF, 1,0,32'hFFFF_FFFF, 0,0, 0,0, 0,0,0,0,
            0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,
            0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 1,32'hDEAD_BEEF, 0,32'hCAFE_F00D, 0,0,0,0,
            0,0,0,0,32'hDEAD_BEEF,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,
            0,0,0,0,32'hDEAD_BEEF,0, 0,0,0,0,32'hDEAD_BEEF,0));
        // reset with pending writes: outputs show stored contents, writes lost
        vecs.push_back(mk(0, 1,5,32'h0000_FFFF, 0,0,0, 1,32'h1, 0,0, 5,9,0,5,
            32'h1234_5678,32'h5555_5555,0,32'h1234_5678,32'hDEAD_BEEF,0,
            32'h1234_5678,32'h5555_5555,0,32'h1234_5678,32'hDEAD_BEEF,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 5,9,0,5,
            0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 1,30,32'd8, 1,31,32'd7, 0,0, 0,0, 30,31,31,30,
            32'd8,32'd7,32'd7,32'd8,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 30,31,31,30,
            32'd8,32'd7,32'd7,32'd8,0,0, 32'd8,32'd7,32'd7,32'd8,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,32'h1234, 1,32'h0BAD_F00D, 30,31,0,0,
            32'd8,32'd7,0,0,0,32'h0BAD_F00D, 32'd8,32'd7,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,
            0,0,0,0,0,32'h0BAD_F00D, 0,0,0,0,0,32'h0BAD_F00D));
        vecs.push_back(mk(1, 1,7,32'd11, 1,8,32'd22, 0,0, 0,0, 7,8,7,8,
            32'd11,32'd22,32'd11,32'd22,0,32'h0BAD_F00D, 0,0,0,0,0,32'h0BAD_F00D));
        // disabled slave write to the same address must not shadow the master
        vecs.push_back(mk(1, 1,7,32'd33, 0,7,32'd44, 0,0, 0,0, 7,8,7,8,
            32'd33,32'd22,32'd33,32'd22,0,32'h0BAD_F00D,
            32'd11,32'd22,32'd11,32'd22,0,32'h0BAD_F00D));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 7,8,7,8,
            32'd33,32'd22,32'd33,32'd22,0,32'h0BAD_F00D,
            32'd33,32'd22,32'd33,32'd22,0,32'h0BAD_F00D));
        vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 7,8,7,8,
            32'd33,32'd22,32'd33,32'd22,0,32'h0BAD_F00D,
            32'd33,32'd22,32'd33,32'd22,0,32'h0BAD_F00D));
        vecs.push_back(mk(0, 1,7,32'd99, 1,8,32'd98, 1,32'h5, 1,32'h6, 7,8,7,8,
            0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 7,8,7,8,
            0,0,0,0,0,0, 0,0,0,0,0,0));

        // initial reset: two edges with rst_n low
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // sweep all addresses on all ports after reset
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) ra[k] = 5'(a);
            #1;
            for (int k = 0; k < 6; k++) begin
                check($sformatf("reset_a%0d_byp_%s", a, port_name[k]), ob[k], 32'h0);
                check($sformatf("reset_a%0d_nob_%s", a, port_name[k]), on[k], 32'h0);
            end
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n  = vecs[i].rst_n;
            m_en   = vecs[i].m_en;   m_addr = vecs[i].m_addr; m_data = vecs[i].m_data;
            s_en   = vecs[i].s_en;   s_addr = vecs[i].s_addr; s_data = vecs[i].s_data;
            hi_wen = vecs[i].hi_wen; hi_wd  = vecs[i].hi_wd;
            lo_wen = vecs[i].lo_wen; lo_wd  = vecs[i].lo_wd;
            for (int k = 0; k < 4; k++) ra[k] = vecs[i].ra[k];
            #1;
            for (int k = 0; k < 6; k++) begin
                check($sformatf("v%0d_byp_%s", i, port_name[k]), ob[k], vecs[i].eb[k]);
                check($sformatf("v%0d_nob_%s", i, port_name[k]), on[k], vecs[i].en[k]);
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_issue_regfile.md
# dual_issue_regfile

Architectural register file for the dual-issue pipeline: 31 general-purpose 32-bit registers plus HI/LO. Provides four combinational read ports to the decode stage (master rs/rt, slave rs/rt), whose outputs are the `reg_data` inputs of the per-operand forwarding units. Accepts two write-back writes per cycle, one from each pipe, with optional write-through bypass so that same-cycle WB results are visible without a forwarding path.

## Interface
Parameters:
- WB_BYPASS, 1, when 1 a read of a register being written this cycle returns the incoming write data; when 0 it returns the stored value.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- master_wb_reg_en  in  1  master pipe GPR write enable
- master_wb_addr  in  5  master write address
- master_wb_data  in  32  master write data
- slave_wb_reg_en  in  1  slave pipe GPR write enable
- slave_wb_addr  in  5  slave write address
- slave_wb_data  in  32  slave write data
- hi_wen  in  1  HI write enable (master pipe only)
- lo_wen  in  1  LO write enable (master pipe only)
- hi_wdata  in  32  HI write data
- lo_wdata  in  32  LO write data
- master_rs_addr, master_rt_addr, slave_rs_addr, slave_rt_addr  in  5 each  read addresses
- master_rs_data, master_rt_data, slave_rs_data, slave_rt_data  out  32 each  read data
- hi_rdata  out  32  current HI
- lo_rdata  out  32  current LO

## Operation
- Storage: regs[1..31], hi, lo; all 32-bit. Register 0 is not stored.
- Reset: on a rising edge with rst_n=0, regs[1..31], hi, lo all become 0. Write enables ignored in that cycle.
- GPR write: at the rising edge with rst_n=1, master writes if master_wb_reg_en and master_wb_addr≠0; slave likewise.
- Write collision (both enabled, same nonzero address): the slave value is stored. The slave instruction is the younger of the pair, so slave wins.
- Writes to address 0 are discarded; a read of address 0 always returns 0, regardless of enables or bypass.
- Read port (each of four, identical logic), evaluated combinationally:
  - addr==0 → 0.
  - Else if WB_BYPASS, rst_n=1, slave_wb_reg_en and slave_wb_addr==addr → slave_wb_data.
  - Else if WB_BYPASS, rst_n=1, master_wb_reg_en and master_wb_addr==addr → master_wb_data.
  - Else → regs[addr].
- HI/LO: hi_wen/lo_wen update independently at the rising edge when rst_n=1. hi_rdata/lo_rdata follow the same bypass rule when WB_BYPASS=1: the value is the write data while the write enable is high and rst_n=1, otherwise the stored value.
- No X propagation: every read output is a defined function of stored state and inputs at all times after the first reset edge.

## Timing
- Write latency: data written at edge N is readable from the array after edge N. With WB_BYPASS=1 it is also visible combinationally during the cycle before edge N.
- Read latency: 0 cycles (combinational from address, stored state and WB inputs).
- Bypass is suppressed while rst_n=0, so outputs during reset show stored contents, which are all 0 after the first reset edge.
- Reset mid-operation: a write presented in the same cycle as rst_n=0 is lost. The registers read 0 from the following cycle.
- Reset asserted for several cycles: contents stay 0 and bypass stays suppressed throughout.

## Test plan
- Reset then read all 32 addresses on all four ports → every output 0; hi_rdata=lo_rdata=0.
- Master writes r5=0x1234_5678; next cycle read r5 on all four ports → 0x1234_5678. With WB_BYPASS=1 the same value also appears during the write cycle; with WB_BYPASS=0 the old value 0 appears then.
- Same cycle: master writes r9=0xAAAA_AAAA and slave writes r9=0x5555_5555 → r9 reads 0x5555_5555 both during that cycle (bypass) and afterwards.
- Both pipes write r0=0xFFFF_FFFF with bypass on → every r0 read is 0, during and after the write.
- hi_wen=1, hi_wdata=0xDEAD_BEEF with lo_wen=0 → hi_rdata=0xDEAD_BEEF and lo unchanged. Then rst_n=0 for one cycle while hi_wen=1, hi_wdata=0x1 → the write is ignored and hi_rdata=0 afterwards.
- Slave writes r31=7 while master writes r30=8, all four ports reading r30/r31 in mixed order → each port shows its own address's value with no cross-talk.
